// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, drives the instruction-memory address, and buffers
// {pc, instruction} pairs in a small FIFO that decode drains over valid/ready.
module fetch_queue #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DEPTH      = 2,
  parameter int          DATA_WIDTH = 32
) (
  input  logic                       iClk,
  input  logic                       iRstN,
  output logic [31:0]                oPC,
  input  logic [DATA_WIDTH-1:0]      iInstruction,
  input  logic                       iRedirect,
  input  logic [31:0]                iRedirectPC,
  output logic                       oValid,
  input  logic                       iReady,
  output logic [DATA_WIDTH-1:0]      oInstr,
  output logic [31:0]                oInstrPC,
  output logic [$clog2(DEPTH):0]     oCount
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: an entry transfers on a cycle where oValid && iReady, except
  // that a redirect in the same cycle wins and nothing is popped. While
  // oValid && !iReady the head (oValid, oInstr, oInstrPC) stays stable.

  logic [31:0]           pc_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [PW-1:0]         wr_ptr_q;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [31:0]           pc_mem    [DEPTH];

  logic pop;
  logic fetch;

  always_comb begin
    pop   = 1'b0;
    fetch = 1'b0;
    if (!iRedirect) begin
      pop   = (count_q != '0) && iReady;
      fetch = (count_q < CW'(DEPTH)) || pop;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (iRedirect) begin
      pc_q     <= {iRedirectPC[31:2], 2'b00};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fetch) begin
        pc_q     <= pc_q + 32'd4;
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({fetch, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the queue is empty.
  always_ff @(posedge iClk) begin
    if (fetch) begin
      instr_mem[wr_ptr_q] <= iInstruction;
      pc_mem[wr_ptr_q]    <= pc_q;
    end
  end

  always_comb begin
    oPC      = pc_q;
    oCount   = count_q;
    oValid   = (count_q != '0);
    oInstr   = '0;
    oInstrPC = '0;
    if (oValid) begin
      oInstr   = instr_mem[rd_ptr_q];
      oInstrPC = pc_mem[rd_ptr_q];
    end
  end

endmodule
